// File: rtl/dcu_pkg.sv
// Shared constants for the decimation control unit: mode codes, FSM state
// encoding and a small mode-decode helper.
package dcu_pkg;

  localparam logic [1:0] MODE_FREE       = 2'b00;
  localparam logic [1:0] MODE_SYNC_START = 2'b01;
  localparam logic [1:0] MODE_ONE_SHOT   = 2'b10;
  localparam logic [1:0] MODE_RESYNC     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  // Modes that start counting immediately instead of waiting for a sync edge.
  function automatic logic starts_free(input logic [1:0] m);
    return (m == MODE_FREE) || (m == MODE_RESYNC);
  endfunction

endpackage

// File: rtl/dcu_edge_det.sv
// Rising-edge detector for a synchronous strobe: one delay register and the
// sig & ~sig_d decode. The delay register updates every clock.
module dcu_edge_det (
  input  logic clk_in,
  input  logic SYSRSTn,
  input  logic sig,
  output logic rise
);

  logic sig_d_r;

  // Delay the input by one clock for edge comparison.
  always_ff @(posedge clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      sig_d_r <= 1'b0;
    end else begin
      sig_d_r <= sig;
    end
  end

  assign rise = sig & ~sig_d_r;

endmodule

// File: rtl/dcu_ctrl.sv
// Decimation control unit: generates the end-of-period strobe osr for the
// sigma-delta decimator with a double-buffered ratio, enable gating and
// external-sync start / one-shot / resync modes.
module dcu_ctrl
  import dcu_pkg::*;
#(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DEC_RST = 8'hFF
) (
  input  logic             clk_in,
  input  logic             SYSRSTn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] value_dec,
  input  logic             value_ld,
  input  logic             sync_in,
  input  logic             err_clr,
  output logic             osr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] active_r, pending_r;
  logic [1:0]       mode_q_r;
  logic             done_r;
  logic             sync_err_r;
  logic             sync_rise_s;
  logic             wrap_s;
  logic             resync_hit_s;

  dcu_edge_det sync_det (
    .clk_in  (clk_in),
    .SYSRSTn (SYSRSTn),
    .sig     (sync_in),
    .rise    (sync_rise_s)
  );

  // End of period is decoded from registers only, so it cannot glitch.
  assign wrap_s       = (state_r == ST_RUN) && (cnt_r == active_r);
  assign resync_hit_s = en && (state_r == ST_RUN) && (mode_q_r == MODE_RESYNC) && sync_rise_s;

  // State and counter registers.
  always_ff @(posedge clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and next-count decode; en low overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (!en) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s = CNT_ZERO;
          if (done_r) begin
            state_nxt_s = ST_IDLE;
          end else if (starts_free(mode)) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_ARMED: begin
          cnt_nxt_s = CNT_ZERO;
          if (sync_rise_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_RUN: begin
          if (resync_hit_s) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_RUN;
          end else if (wrap_s) begin
            cnt_nxt_s = CNT_ZERO;
            if (mode_q_r == MODE_ONE_SHOT) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    osr      = wrap_s;
    busy     = (state_r != ST_IDLE);
    cnt      = cnt_r;
    sync_err = sync_err_r;
  end

  // Double-buffered ratio: active only follows pending at a wrap or while
  // not counting, so a load never reshapes the period in flight.
  always_ff @(posedge clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      pending_r <= DEC_RST;
      active_r  <= DEC_RST;
    end else begin
      if (value_ld) begin
        pending_r <= value_dec;
      end else begin
        pending_r <= pending_r;
      end
      if (wrap_s || (state_r == ST_IDLE) || (state_r == ST_ARMED)) begin
        active_r <= pending_r;
      end else begin
        active_r <= active_r;
      end
    end
  end

  // Mode latch on leaving IDLE, and one-shot completion flag that blocks
  // re-arming until en has been dropped.
  always_ff @(posedge clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      mode_q_r <= MODE_FREE;
      done_r   <= 1'b0;
    end else begin
      if (en && (state_r == ST_IDLE) && !done_r) begin
        mode_q_r <= mode;
      end else begin
        mode_q_r <= mode_q_r;
      end
      if (!en) begin
        done_r <= 1'b0;
      end else if (wrap_s && (mode_q_r == MODE_ONE_SHOT)) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

  // Sticky phase-error flag: a resync landing anywhere but the wrap sets it;
  // set wins over clear.
  always_ff @(posedge clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      sync_err_r <= 1'b0;
    end else if (resync_hit_s && !wrap_s) begin
      sync_err_r <= 1'b1;
    end else if (err_clr) begin
      sync_err_r <= 1'b0;
    end else begin
      sync_err_r <= sync_err_r;
    end
  end

endmodule
